// File: rtl/seq_divider_hs.sv
// seq_divider_hs: multi-cycle restoring divider with valid/ready handshakes.
// Signed or unsigned per operation; one quotient bit per cycle.
// Flags divide-by-zero and signed MIN / -1 overflow.
// Counting the accept edge as the first edge, out_valid rises on edge
// WIDTH+2 for a non-zero divisor and on that same accept edge for a zero divisor.
module seq_divider_hs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    input  logic             signed_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    // Dividend magnitude shifts out MSB first while quotient bits shift in at
    // the LSB, so after WIDTH steps this register holds the quotient magnitude.
    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ovf;

    logic             w_accept;
    logic             w_num_neg;
    logic             w_den_neg;
    logic [WIDTH-1:0] w_num_mag;
    logic [WIDTH-1:0] w_den_mag;
    logic             w_num_min;
    logic             w_den_m1;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign in_ready  = (r_state == IDLE);
    assign w_accept  = in_valid & in_ready;

    assign w_num_neg = signed_op & numerator[WIDTH-1];
    assign w_den_neg = signed_op & denominator[WIDTH-1];
    // MIN negates to itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign w_num_mag = w_num_neg ? (WIDTH'(0) - numerator)   : numerator;
    assign w_den_mag = w_den_neg ? (WIDTH'(0) - denominator) : denominator;
    assign w_num_min = (numerator == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_den_m1  = (denominator == {WIDTH{1'b1}});

    // Shifted partial remainder needs WIDTH+1 bits; the compare uses all of them.
    // When rem' >= den the difference is below den, so WIDTH bits hold it exactly.
    assign w_rem_sh  = {r_rem, r_num[WIDTH-1]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_den});
    assign w_diff    = w_rem_sh[WIDTH-1:0] - r_den;

    // Control FSM, datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_num       <= '0;
            r_den       <= '0;
            r_rem       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        if (denominator == '0) begin
                            quotient    <= '1;
                            remainder   <= numerator;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_num   <= w_num_mag;
                            r_den   <= w_den_mag;
                            r_rem   <= '0;
                            r_neg_q <= w_num_neg ^ w_den_neg;
                            r_neg_r <= w_num_neg;
                            r_ovf   <= signed_op & w_num_min & w_den_m1;
                            r_cnt   <= CW'(WIDTH - 1);
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_rem   <= w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
                    r_num   <= {r_num[WIDTH-2:0], w_ge};
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // MIN / -1 needs no special case: magnitude 2^(WIDTH-1) / 1
                    // with positive sign yields MIN, remainder 0.
                    quotient  <= r_neg_q ? (WIDTH'(0) - r_num) : r_num;
                    remainder <= r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;
                    overflow  <= r_ovf;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_hs.sv
// Directed and randomized bench for seq_divider_hs at WIDTH=8.
module tb_seq_divider_hs;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] numerator;
    logic [W-1:0] denominator;
    logic         signed_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider_hs #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .numerator   (numerator),
        .denominator (denominator),
        .signed_op   (signed_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model built on the language's own division operators.
    function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sn;
        int sd;
        dz = 1'b0;
        ov = 1'b0;
        if (d == '0) begin
            q  = '1;
            r  = n;
            dz = 1'b1;
        end else if (s) begin
            sn = int'($signed(n));
            sd = int'($signed(d));
            if (sn == -(1 << (W - 1)) && sd == -1) begin
                q  = {1'b1, {(W-1){1'b0}}};
                r  = '0;
                ov = 1'b1;
            end else begin
                q = W'(sn / sd);
                r = W'(sn % sd);
            end
        end else begin
            q = n / d;
            r = n % d;
        end
    endfunction

    // One transaction: accept, wait for result (bounded), optional stall, drain.
    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                          input int stall,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic ov, output int lat);
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'(1));
        in_valid    = 1'b1;
        numerator   = n;
        denominator = d;
        signed_op   = s;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        // Scramble inputs after accept; the DUT must ignore them.
        in_valid    = 1'b0;
        numerator   = ~n;
        denominator = ~d;
        signed_op   = ~s;
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid", 32'(out_valid), 32'(1));
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
        ov = overflow;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check("hold", {18'd0, out_valid, in_ready, div_by_zero, overflow, quotient, remainder},
                  {18'd0, 1'b1, 1'b0, dz, ov, q, r});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic dir(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic s, input int stall,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic edz, input logic eov, input int elat);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
        run_op(n, d, s, stall, q, r, dz, ov, lat);
        check({tag, "_q"},   32'(q),   32'(eq));
        check({tag, "_r"},   32'(r),   32'(er));
        check({tag, "_dz"},  32'(dz),  32'(edz));
        check({tag, "_ov"},  32'(ov),  32'(eov));
        check({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rn, rd, eq, er, q, r;
        logic         rs, edz, eov, dz, ov, seen;
        int           lat;

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        numerator   = '0;
        denominator = '0;
        signed_op   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_state", {22'd0, in_ready, out_valid, div_by_zero, overflow, quotient, remainder},
              {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});

        // Unsigned, signed, overflow and zero-divisor vectors.
        dir("u200_7",   8'd200, 8'd7,   1'b0, 0, 8'd28,  8'd4,  1'b0, 1'b0, W + 2);
        dir("sm7_2",    8'hF9,  8'h02,  1'b1, 0, 8'hFD,  8'hFF, 1'b0, 1'b0, W + 2);
        dir("s7_m2",    8'h07,  8'hFE,  1'b1, 0, 8'hFD,  8'h01, 1'b0, 1'b0, W + 2);
        dir("s_ovf",    8'h80,  8'hFF,  1'b1, 0, 8'h80,  8'h00, 1'b0, 1'b1, W + 2);
        dir("u80_ff",   8'h80,  8'hFF,  1'b0, 0, 8'h00,  8'h80, 1'b0, 1'b0, W + 2);
        dir("smin_1",   8'h80,  8'h01,  1'b1, 0, 8'h80,  8'h00, 1'b0, 1'b0, W + 2);
        dir("uff_1",    8'hFF,  8'h01,  1'b0, 0, 8'hFF,  8'h00, 1'b0, 1'b0, W + 2);
        dir("dz_s",     8'h5A,  8'h00,  1'b1, 0, 8'hFF,  8'h5A, 1'b1, 1'b0, 1);
        dir("dz_u",     8'h5A,  8'h00,  1'b0, 0, 8'hFF,  8'h5A, 1'b1, 1'b0, 1);
        // Flags must clear on the next accept.
        dir("after_dz", 8'd9,   8'd3,   1'b0, 0, 8'd3,   8'd0,  1'b0, 1'b0, W + 2);

        // Backpressure: 20 stalled cycles with in_valid asserted, then one pulse.
        dir("bp",       8'd100, 8'd9,   1'b0, 20, 8'd11, 8'd1,  1'b0, 1'b0, W + 2);

        // Reset during the 4th RUN cycle abandons the operation.
        @(negedge clk);
        in_valid    = 1'b1;
        numerator   = 8'd200;
        denominator = 8'd3;
        signed_op   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst", {22'd0, in_ready, out_valid, div_by_zero, overflow, quotient, remainder},
              {22'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("midrst_noval", 32'(seen), 32'(0));
        dir("u255_255", 8'hFF,  8'hFF,  1'b0, 0, 8'd1,   8'd0,  1'b0, 1'b0, W + 2);

        // Random operands and stalls against the reference model.
        for (int k = 0; k < 300; k++) begin
            rn = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rd = '0;
                1:       rd = '1;
                2:       rd = 8'd1;
                default: rd = W'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) rn = 8'h80;
            rs = 1'($urandom_range(0, 1));
            model(rn, rd, rs, eq, er, edz, eov);
            run_op(rn, rd, rs, $urandom_range(0, 3), q, r, dz, ov, lat);
            check("rnd", {14'd0, q, r, dz, ov}, {14'd0, eq, er, edz, eov});
            check("rnd_lat", 32'(lat), (rd == '0) ? 32'(1) : 32'(W + 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
